pgm_sched: RTL and testbench

Packet-generation scheduler that sequences the PGM read engine. It issues one start pulse per generated packet, enforces a programmable inter-packet gap, and tags every Nth packet as a latency probe. It asserts finish on the last packet of a programmed burst, and supervises each packet with a watchdog. It sits between the UA/DMA config path (simple register port) and the PGM read engine, replacing free-running start/finish flags.

---
 rtl/pgm_sched.sv | 216 +++++++++++++++++++++
 tb/tb_pgm_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_sched.sv
`default_nettype none
// ============================================================================
// Module   : pgm_sched
// Purpose  : Packet-generation scheduler for the PGM read engine. Issues one
//            start pulse per packet, enforces a programmable inter-packet gap,
//            tags every Nth packet as a latency probe, flags the last packet
//            of a burst and supervises each packet with a watchdog.
// Ports    : clk, rst              clock, synchronous active-high reset
//            cfg_wr/cfg_rd         register write / read strobes
//            cfg_addr, cfg_wdata   register address and write data
//            cfg_rdata             read data, valid one cycle after cfg_rd
//            in_rd_alf             downstream almost-full, blocks new starts
//            rd_eop                read engine emitted a packet tail
//            sched_start/probe     start pulse and its probe qualifier
//            sched_finish          current/last packet ends the burst
//            sched_busy/done/err   state levels and sticky watchdog error
// Revision : 1.0 - initial release
// ============================================================================
module pgm_sched #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic             cfg_rd,
    input  logic [2:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    output logic [CNT_W-1:0] cfg_rdata,
    input  logic             in_rd_alf,
    input  logic             rd_eop,
    output logic             sched_start,
    output logic             sched_probe,
    output logic             sched_finish,
    output logic             sched_busy,
    output logic             sched_done,
    output logic             sched_err
);

    localparam int              WD_W      = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] c_wd_last = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_gap_rst = CNT_W'(1000);
    localparam logic [CNT_W-1:0] c_ones    = '1;
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_gap   = 3'd1;
    localparam logic [2:0] c_st_busy  = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_pkt_total, r_gap_cfg, r_gap_lim, r_probe_int;
    logic [CNT_W-1:0] r_gap_cnt, r_probe_left, r_sent_cnt, r_probe_cnt;
    logic [CNT_W-1:0] r_rdata;
    logic [WD_W-1:0]  r_wd_cnt;
    logic             r_cur_probe, r_err, r_stray, r_start, r_probe, r_finish;

    logic             w_ctrl_wr, w_enable, w_abort, w_idle_like, w_eop_ok;
    logic             w_last_pkt, w_probe_hit, w_wd_expired;
    logic [CNT_W-1:0] w_sent_next, w_probe_next, w_rd_mux;

    assign w_ctrl_wr    = cfg_wr && (cfg_addr == 3'd0);
    assign w_enable     = w_ctrl_wr && cfg_wdata[0];
    assign w_abort      = w_ctrl_wr && cfg_wdata[1];
    assign w_idle_like  = (r_state == c_st_idle) || (r_state == c_st_done);
    assign w_eop_ok     = rd_eop && ((r_state == c_st_busy) || (r_state == c_st_drain));
    // Packet being started has index sent+1, so it is the last one when
    // sent == total-1 (total of zero means a continuous burst).
    assign w_last_pkt   = (r_pkt_total != '0) && (r_sent_cnt == r_pkt_total - c_one);
    // Down-counter reaching 1 marks every PROBE_INT-th packet without a divider.
    assign w_probe_hit  = (r_probe_int != '0) && (r_probe_left == c_one);
    assign w_wd_expired = (r_wd_cnt == c_wd_last);
    assign w_sent_next  = (r_sent_cnt == c_ones) ? r_sent_cnt : r_sent_cnt + c_one;
    assign w_probe_next = (r_probe_cnt == c_ones) ? r_probe_cnt : r_probe_cnt + c_one;

    always_comb begin
        w_rd_mux = '0;
        case (cfg_addr)
            3'd0:    w_rd_mux = CNT_W'(sched_busy);
            3'd1:    w_rd_mux = r_pkt_total;
            3'd2:    w_rd_mux = r_gap_cfg;
            3'd3:    w_rd_mux = r_probe_int;
            3'd4:    w_rd_mux = r_sent_cnt;
            3'd5:    w_rd_mux = r_probe_cnt;
            3'd6:    w_rd_mux = CNT_W'({r_err, r_stray, r_state});
            default: w_rd_mux = c_ones;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_pkt_total  <= '0;
            r_gap_cfg    <= c_gap_rst;
            r_gap_lim    <= c_gap_rst;
            r_probe_int  <= '0;
            r_gap_cnt    <= '0;
            r_probe_left <= '0;
            r_sent_cnt   <= '0;
            r_probe_cnt  <= '0;
            r_rdata      <= '0;
            r_wd_cnt     <= '0;
            r_cur_probe  <= 1'b0;
            r_err        <= 1'b0;
            r_stray      <= 1'b0;
            r_start      <= 1'b0;
            r_probe      <= 1'b0;
            r_finish     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_probe <= 1'b0;

            // Read samples the pre-write register contents.
            if (cfg_rd)
                r_rdata <= w_rd_mux;
            if (cfg_wr && (cfg_addr == 3'd2))
                r_gap_cfg <= cfg_wdata;
            if (cfg_wr && w_idle_like && (cfg_addr == 3'd1))
                r_pkt_total <= cfg_wdata;
            if (cfg_wr && w_idle_like && (cfg_addr == 3'd3))
                r_probe_int <= cfg_wdata;

            if (w_eop_ok) begin
                r_sent_cnt <= w_sent_next;
                if (r_cur_probe)
                    r_probe_cnt <= w_probe_next;
            end

            case (r_state)
                c_st_idle, c_st_done: begin
                    if (w_enable) begin
                        r_sent_cnt   <= '0;
                        r_probe_cnt  <= '0;
                        r_err        <= 1'b0;
                        r_stray      <= 1'b0;
                        r_finish     <= 1'b0;
                        r_probe_left <= r_probe_int;
                        // Preloading the count makes the first start immediate.
                        r_gap_lim    <= r_gap_cfg;
                        r_gap_cnt    <= r_gap_cfg;
                        r_state      <= c_st_gap;
                    end else if (w_ctrl_wr && (r_state == c_st_done)) begin
                        r_finish <= 1'b0;
                        r_state  <= c_st_idle;
                    end
                end
                c_st_gap: begin
                    if (w_abort) begin
                        r_state <= c_st_done;
                    end else if (!in_rd_alf) begin
                        // The gap only advances while downstream has room.
                        if (r_gap_cnt < r_gap_lim) begin
                            r_gap_cnt <= r_gap_cnt + c_one;
                        end else begin
                            r_start     <= 1'b1;
                            r_probe     <= w_probe_hit;
                            r_cur_probe <= w_probe_hit;
                            if (r_probe_int != '0)
                                r_probe_left <= w_probe_hit ? r_probe_int : r_probe_left - c_one;
                            if (w_last_pkt)
                                r_finish <= 1'b1;
                            r_wd_cnt <= '0;
                            r_state  <= c_st_busy;
                        end
                    end
                end
                c_st_busy: begin
                    if (rd_eop) begin
                        if (r_finish || w_abort) begin
                            r_state <= c_st_done;
                        end else begin
                            r_gap_lim <= r_gap_cfg;
                            r_gap_cnt <= '0;
                            r_state   <= c_st_gap;
                        end
                    end else if (w_wd_expired) begin
                        r_err   <= 1'b1;
                        r_state <= c_st_done;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WD_W'(1);
                        if (w_abort)
                            r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    // Let the in-flight packet finish; never truncate it.
                    if (rd_eop) begin
                        r_state <= c_st_done;
                    end else if (w_wd_expired) begin
                        r_err   <= 1'b1;
                        r_state <= c_st_done;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WD_W'(1);
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            // Tail outside a packet: ignored, but remembered for diagnosis.
            if (rd_eop && !w_eop_ok)
                r_stray <= 1'b1;
        end
    end

    assign cfg_rdata    = r_rdata;
    assign sched_start  = r_start;
    assign sched_probe  = r_probe;
    assign sched_finish = r_finish;
    assign sched_busy   = (r_state == c_st_gap) || (r_state == c_st_busy) ||
                          (r_state == c_st_drain);
    assign sched_done   = (r_state == c_st_done);
    assign sched_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pgm_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pgm_sched
// Purpose  : Self-checking bench for pgm_sched: table-driven bursts, random
//            bursts with almost-full back-pressure against a burst-level
//            reference model, and directed abort/watchdog/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pgm_sched;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_wr, cfg_rd;
    logic [2:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_wdata, cfg_rdata;
    logic             in_rd_alf, rd_eop;
    logic             sched_start, sched_probe, sched_finish;
    logic             sched_busy, sched_done, sched_err;

    always #5 clk = ~clk;

    pgm_sched #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .in_rd_alf(in_rd_alf), .rd_eop(rd_eop), .sched_start(sched_start),
        .sched_probe(sched_probe), .sched_finish(sched_finish),
        .sched_busy(sched_busy), .sched_done(sched_done), .sched_err(sched_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-engine model plus monitor: answers each start with an eop after
    // eng_lat cycles, and logs starts/eops with their cycle numbers.
    bit eng_on        = 1'b0;
    int eng_lat       = 5;
    int force_eop_cyc = -1;
    int due_q[$];
    int start_log[$];
    bit probe_log[$];
    bit fin_log[$];
    int eop_log[$];
    bit alf_hist [0:99999];

    always @(negedge clk) begin
        logic e;
        if (!eng_on) due_q.delete();
        e = (force_eop_cyc == cyc);
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            e = 1'b1;
            void'(due_q.pop_front());
        end
        rd_eop = e;
        if (e) eop_log.push_back(cyc);
        if (sched_start) begin
            start_log.push_back(cyc);
            probe_log.push_back(sched_probe);
            fin_log.push_back(sched_finish);
            if (eng_on) due_q.push_back(cyc + eng_lat);
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input int d, output int wcyc);
        cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d; wcyc = cyc;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic cfg_read(input logic [2:0] a, output logic [CNT_W-1:0] d);
        cfg_rd = 1'b1; cfg_addr = a;
        @(negedge clk);
        cfg_rd = 1'b0;
        d = cfg_rdata;
    endtask

    // Runs one burst and checks it against the burst-level rules: first
    // start one cycle after the first alf-low cycle following enable; later
    // starts one cycle after the (gap+1)-th alf-low cycle following an eop.
    task automatic run_burst(input int g, input int t, input int p, input int l,
                             input int pct, input int exp_sp, input int exp_pc);
        int w, base, ebase, n, nst, neop, c, need;
        logic [CNT_W-1:0] d;
        cfg_write(3'd0, 0, w);
        cfg_write(3'd2, g, w);
        cfg_write(3'd1, t, w);
        cfg_write(3'd3, p, w);
        eng_lat = l; eng_on = 1'b1;
        base = start_log.size(); ebase = eop_log.size();
        cfg_write(3'd0, 1, w);
        n = 0;
        while (!sched_done && n < 3000) begin
            in_rd_alf = (pct > 0) && ($urandom_range(99) < pct);
            alf_hist[cyc] = in_rd_alf;
            @(negedge clk);
            n++;
        end
        in_rd_alf = 1'b0; alf_hist[cyc] = 1'b0;
        chk("burst_done", sched_done, 1);
        chk("burst_finish_held", sched_finish, 1);
        eng_on = 1'b0;
        @(negedge clk);
        nst  = start_log.size() - base;
        neop = eop_log.size() - ebase;
        chk("burst_starts", nst, t);
        chk("burst_eops", neop, t);
        for (int k = 1; k <= nst && k <= t && k - 1 <= neop; k++) begin
            if (k == 1) begin c = w + 1; need = 1; end
            else begin c = eop_log[ebase + k - 2] + 1; need = g + 1; end
            while (need > 0 && c < cyc) begin
                if (!alf_hist[c]) need--;
                if (need > 0) c++;
            end
            chk("start_cycle", start_log[base + k - 1], c + 1);
            chk("start_probe", probe_log[base + k - 1], (p != 0) && (k % p == 0));
            chk("start_finish", fin_log[base + k - 1], k == t);
            if (exp_sp >= 0 && k > 1)
                chk("start_spacing", start_log[base + k - 1] - start_log[base + k - 2], exp_sp);
        end
        cfg_read(3'd4, d); chk("sent_cnt", d, t);
        cfg_read(3'd5, d); chk("probe_cnt", d, exp_pc);
        cfg_read(3'd6, d); chk("status_done", d, 4);
    endtask

    typedef struct {
        int gap; int total; int probe; int lat; int exp_spacing; int exp_pcnt;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[4];
        logic [CNT_W-1:0] d;
        int w, a, s, e, f, base, ebase, n, g, t, p, l;

        tbl[0] = '{gap: 3, total: 4, probe: 0, lat: 5, exp_spacing: 10, exp_pcnt: 0};
        tbl[1] = '{gap: 0, total: 7, probe: 3, lat: 2, exp_spacing: 4,  exp_pcnt: 2};
        tbl[2] = '{gap: 1, total: 5, probe: 1, lat: 3, exp_spacing: 6,  exp_pcnt: 5};
        tbl[3] = '{gap: 2, total: 3, probe: 2, lat: 1, exp_spacing: 5,  exp_pcnt: 1};

        rst = 1'b1; cfg_wr = 1'b0; cfg_rd = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_rd_alf = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_start", sched_start, 0);
        chk("rst_probe", sched_probe, 0);
        chk("rst_finish", sched_finish, 0);
        chk("rst_busy", sched_busy, 0);
        chk("rst_done", sched_done, 0);
        chk("rst_err", sched_err, 0);
        chk("rst_rdata", cfg_rdata, 0);
        cfg_read(3'd2, d); chk("rst_gap", d, 1000);
        cfg_read(3'd1, d); chk("rst_pkt_total", d, 0);
        cfg_read(3'd3, d); chk("rst_probe_int", d, 0);
        cfg_read(3'd4, d); chk("rst_sent", d, 0);
        cfg_read(3'd6, d); chk("rst_status", d, 0);
        cfg_read(3'd7, d); chk("addr7", d, 32'hffffffff);

        // Simultaneous read and write to the same address
        cfg_wr = 1'b1; cfg_rd = 1'b1; cfg_addr = 3'd2; cfg_wdata = 7;
        @(negedge clk);
        cfg_wr = 1'b0; cfg_rd = 1'b0;
        chk("rw_same_cycle", cfg_rdata, 1000);
        cfg_read(3'd2, d); chk("rw_after", d, 7);

        // Table-driven bursts, no back-pressure
        for (int i = 0; i < 4; i++)
            run_burst(tbl[i].gap, tbl[i].total, tbl[i].probe, tbl[i].lat, 0,
                      tbl[i].exp_spacing, tbl[i].exp_pcnt);

        // Random bursts with almost-full back-pressure
        for (int i = 0; i < 6; i++) begin
            g = $urandom_range(4);
            t = $urandom_range(6, 1);
            p = $urandom_range(3);
            l = $urandom_range(8, 1);
            run_burst(g, t, p, l, 30, -1, (p == 0) ? 0 : t / p);
        end

        // GAP=0 with almost-full held for 20 cycles after the first eop
        cfg_write(3'd0, 0, w); cfg_write(3'd2, 0, w);
        cfg_write(3'd1, 2, w); cfg_write(3'd3, 0, w);
        eng_lat = 3; eng_on = 1'b1;
        base = start_log.size(); ebase = eop_log.size();
        cfg_write(3'd0, 1, w);
        n = 0;
        while (eop_log.size() == ebase && n < 100) begin @(negedge clk); #1; n++; end
        chk("alf_first_eop", eop_log.size() - ebase, 1);
        in_rd_alf = 1'b1;
        repeat (21) @(negedge clk);
        #1;
        in_rd_alf = 1'b0; f = cyc;
        chk("alf_no_start", start_log.size() - base, 1);
        repeat (3) @(negedge clk);
        #1;
        if (start_log.size() - base >= 2) chk("alf_release_start", start_log[base + 1], f + 1);
        else chk("alf_release_start_missing", start_log.size() - base, 2);
        n = 0;
        while (!sched_done && n < 100) begin @(negedge clk); n++; end
        chk("alf_done", sched_done, 1);
        eng_on = 1'b0;

        // Abort mid-BUSY: drain the in-flight packet, then DONE
        cfg_write(3'd0, 0, w); cfg_write(3'd2, 2, w); cfg_write(3'd1, 0, w);
        base = start_log.size();
        cfg_write(3'd0, 1, w);
        @(negedge clk);
        chk("abort_start", sched_start, 1);
        force_eop_cyc = cyc + 4;
        cfg_write(3'd0, 2, a);
        cfg_read(3'd6, d); chk("abort_drain_state", d, 3);
        chk("abort_drain_busy", sched_busy, 1);
        repeat (4) @(negedge clk);
        #1;
        chk("abort_done", sched_done, 1);
        chk("abort_no_new_start", start_log.size() - base, 1);
        cfg_read(3'd4, d); chk("abort_sent", d, 1);

        // Abort in GAP: DONE the next cycle
        cfg_write(3'd2, 50, w); cfg_write(3'd0, 0, w);
        base = start_log.size();
        cfg_write(3'd0, 1, w);
        @(negedge clk);
        force_eop_cyc = cyc + 1;
        repeat (5) @(negedge clk);
        chk("gap_abort_busy", sched_busy, 1);
        cfg_write(3'd0, 2, a);
        chk("gap_abort_done", sched_done, 1);
        chk("gap_abort_starts", start_log.size() - base, 1);
        cfg_read(3'd4, d); chk("gap_abort_sent", d, 1);

        // Watchdog: no eop after start
        cfg_write(3'd0, 0, w); cfg_write(3'd2, 0, w);
        cfg_write(3'd0, 1, w);
        @(negedge clk);
        chk("wd_start", sched_start, 1);
        repeat (15) @(negedge clk);
        chk("wd_not_yet", sched_done, 0);
        @(negedge clk);
        chk("wd_done", sched_done, 1);
        chk("wd_err", sched_err, 1);
        cfg_read(3'd6, d); chk("wd_status", d, 20);
        cfg_write(3'd0, 1, w);
        chk("wd_err_cleared", sched_err, 0);
        repeat (20) @(negedge clk);

        // Reset mid-burst in continuous mode
        cfg_write(3'd0, 0, w); cfg_write(3'd2, 1, w);
        cfg_write(3'd1, 0, w); cfg_write(3'd3, 0, w);
        eng_lat = 2; eng_on = 1'b1;
        base = start_log.size();
        cfg_write(3'd0, 1, w);
        n = 0;
        while (start_log.size() - base < 3 && n < 200) begin @(negedge clk); #1; n++; end
        chk("cont_three_starts", start_log.size() - base >= 3, 1);
        cfg_write(3'd1, 5, w);
        cfg_read(3'd1, d); chk("total_write_dropped", d, 0);
        cfg_write(3'd2, 9, w);
        cfg_read(3'd2, d); chk("gap_write_busy", d, 9);
        chk("cont_busy", sched_busy, 1);
        rst = 1'b1; eng_on = 1'b0;
        @(negedge clk);
        chk("mid_rst_start", sched_start, 0);
        chk("mid_rst_probe", sched_probe, 0);
        chk("mid_rst_finish", sched_finish, 0);
        chk("mid_rst_busy", sched_busy, 0);
        chk("mid_rst_done", sched_done, 0);
        chk("mid_rst_err", sched_err, 0);
        chk("mid_rst_rdata", cfg_rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        cfg_read(3'd2, d); chk("mid_rst_gap", d, 1000);
        cfg_read(3'd1, d); chk("mid_rst_total", d, 0);
        cfg_read(3'd4, d); chk("mid_rst_sent", d, 0);

        // Stray eop in IDLE
        force_eop_cyc = cyc + 1;
        repeat (2) @(negedge clk);
        cfg_read(3'd6, d); chk("stray_status", d, 8);
        chk("stray_no_start", sched_start, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
